ps2mouse_dev: RTL
=================

# ps2mouse_dev

Synthesizable PS/2 mouse device emulator. It is the upstream stage of the host-side PS/2 mouse controller: it drives and receives on the shared open-collector `mclk`/`mdat` lines. It answers host commands (reset, sample rate, device ID, enable/disable) and streams 3- or 4-byte movement packets built from a simple stimulus port. It is used in the PS/2 mouse bench and as an on-board loopback source.

## Interface
- `CLK_HALF`, default 32: PS/2 clock half-period, in `clk` cycles.
- `RTS_MIN`, default 256: minimum clock-low time, in cycles, that counts as a host inhibit / request-to-send.
- `GAP`, default 128: idle cycles with the line high before each device-to-host byte.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `mclk_in` in 1: sensed PS/2 clock line.
- `mdat_in` in 1: sensed PS/2 data line.
- `mclk_oe` out 1: 1 pulls the clock line low; 0 releases it.
- `mdat_oe` out 1: 1 pulls the data line low; 0 releases it.
- `move_valid` in 1: a movement sample is offered.
- `move_ready` out 1: one-cycle pulse when the sample is accepted.
- `dx` in 8: two's-complement X delta.
- `dy` in 8: two's-complement Y delta.
- `dz` in 4: two's-complement wheel delta.
- `btn` in 3: buttons {middle, right, left}, 1 = pressed.
- `streaming` out 1: data reporting is enabled.
- `dev_id` out 8: current device ID, 8'h00 or 8'h03.

## Operation
- **Input sync:** `mclk_in` and `mdat_in` each pass through a 2-flop synchronizer. All decisions use the synchronized values.
- **Device frame (device to host):**
  - Bit order: start 0, data LSB first, odd parity, stop 1.
  - Each bit is placed on `mdat_oe` at the start of a clock-high half.
  - The clock-low half follows, so the host samples after the falling edge.
- **Host frame (host to device):**
  - Request detection: clock low for at least `RTS_MIN` cycles, then released while data is low.
  - The device then generates clocks. After each clock-low half it samples data at the midpoint of the following high half.
  - Sample order: bits 0–7, then parity, then stop.
  - Ack: after the stop bit the device asserts `mdat_oe` and generates an 11th clock-low half. It releases data at the end of the following high half.
  - A parity error or stop = 0 queues FE instead of executing the command.
- **Command handling (replies are queued in a FIFO):**
  - FF: FA, AA, 00. Also sets `streaming` = 0, `dev_id` = 00 and clears the rate history.
  - F3: FA. The next received byte is taken as a rate; it replies FA and is pushed into a 3-deep rate history.
  - F2: FA, then `dev_id`.
  - F4: FA and `streaming` = 1.
  - F5: FA and `streaming` = 0.
  - Any other byte: FA.
  - Magic sequence: history equal to {C8, 64, 50} (oldest first) sets `dev_id` = 03.
- **Movement:** accepted when `streaming` is set, the FIFO is empty and no transfer is in progress (`move_ready` pulses that cycle). Pushed bytes, in order:
  - {2'b00, dy[7], dx[7], 1'b1, btn}
  - dx
  - dy
  - {4{dz[3]}, dz}, only when `dev_id` = 03.
- **Top FSM states:**
  - IDLE: clock released.
  - INHIBIT: clock held low by the host.
  - RX: clocking a host frame.
  - ACK: the ack clock pulse.
  - GAP: waiting `GAP` cycles before a byte.
  - TX: sending the byte.
  - Transitions:
    - IDLE → INHIBIT when clock is low.
    - IDLE → GAP when the FIFO is non-empty.
    - GAP → TX after `GAP` cycles of clock high.
    - TX → IDLE after the stop bit half; pop the byte.
    - INHIBIT → RX on release with data low.
    - INHIBIT → IDLE on release with data high.
    - RX → ACK → IDLE.
- **TX abort:** if the clock is sensed low during a device-released high half (host inhibit), TX aborts without popping and goes to INHIBIT. The byte is resent later.
- **Host command during pending replies:** a new host command flushes the FIFO before its own replies are queued.

## Timing
- Reset values:
  - `mclk_oe` = 0, `mdat_oe` = 0, `move_ready` = 0.
  - `streaming` = 0, `dev_id` = 00.
  - FIFO empty, FSM in IDLE, rate history cleared.
- Bit period is 2×`CLK_HALF` cycles. A byte is 11 periods, plus `GAP` idle cycles before it.
- First host-frame clock-low begins `CLK_HALF` cycles after the release is sensed.
- Replies become eligible to send the cycle after ACK completes.
- Reset mid-frame releases both lines on the next cycle.

## Structure
- Shared package `ps2_pkg`:
  - Command constants (FF, F3, F2, F4, F5).
  - Response constants (FA, AA, FE).
  - ID constants (00, 03).
  - Magic rate constants (C8, 64, 50).
  - FSM state enum.
- Sub-module `ps2_byte_fifo`: 8-deep, 8-bit, synchronous push/pop/flush. Full condition drops the push and holds `move_ready` low.

## Test plan
- Host sends FF → device acks, then sends FA, AA, 00; `streaming` = 0.
- Host sends F3 C8, F3 64, F3 50, F2 → each byte answered FA; final replies FA, 03; `dev_id` = 03.
- With ID 03: F4 → FA. Then `dx` = 05, `dy` = FE, `dz` = F, `btn` = 001 → host receives 29, 05, FE, FF.
- With ID 00: same stimulus → host receives exactly three bytes 29, 05, FE.
- Host frame with wrong parity → ack given, reply FE, state unchanged.
- Host pulls clock low mid-TX of AA → abort; after release, AA is retransmitted whole.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 mouse device emulator.
// Command, response, ID and magic-rate bytes plus the top FSM states.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_RATE    = 8'hF3;
  localparam logic [7:0] CMD_GETID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_DISABLE = 8'hF5;

  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_BAT = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hFE;

  localparam logic [7:0] ID_STD   = 8'h00;
  localparam logic [7:0] ID_WHEEL = 8'h03;

  localparam logic [7:0] RATE_M0 = 8'hC8;
  localparam logic [7:0] RATE_M1 = 8'h64;
  localparam logic [7:0] RATE_M2 = 8'h50;

  localparam int FIFO_AW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RX,
    S_ACK,
    S_GAP,
    S_TX
  } state_t;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// 8-deep byte FIFO holding replies and movement bytes.
// A push while full is dropped; flush empties it in one cycle.
module ps2_byte_fifo
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  logic [7:0]         mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] wp;
  logic [FIFO_AW-1:0] rp;
  logic [FIFO_AW:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign empty   = (cnt == '0);
  assign full    = cnt[FIFO_AW];
  assign rdata   = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2mouse_dev.sv
// PS/2 mouse device emulator: answers host commands and streams
// 3/4-byte movement packets over open-collector mclk/mdat.
module ps2mouse_dev
  import ps2_pkg::*;
#(
  parameter int CLK_HALF = 32,
  parameter int RTS_MIN  = 256,
  parameter int GAP      = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mclk_in,
  input  logic       mdat_in,
  output logic       mclk_oe,
  output logic       mdat_oe,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [7:0] dx,
  input  logic [7:0] dy,
  input  logic [3:0] dz,
  input  logic [2:0] btn,
  output logic       streaming,
  output logic [7:0] dev_id
);

  localparam logic [15:0] HALF_M1 = 16'(CLK_HALF - 1);
  localparam logic [15:0] MID     = 16'(CLK_HALF / 2);
  localparam logic [15:0] RTS     = 16'(RTS_MIN);
  localparam logic [15:0] GAP_M1  = 16'(GAP - 1);

  logic [1:0]  cs_q;
  logic [1:0]  ds_q;
  logic        c_s;
  logic        d_s;
  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic [4:0]  h;
  logic [4:0]  h_nx;
  logic        mclk_nx;
  logic        mdat_nx;
  logic        pop;
  logic        ack_done;
  logic        rx_shift;
  logic        half_end;
  logic [9:0]  rx_sr;
  logic [7:0]  rx_byte;
  logic        frame_ok;
  logic [31:0] pend;
  logic [2:0]  pend_n;
  logic        rate_mode;
  logic [7:0]  hist1;
  logic [7:0]  hist2;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;
  logic        fifo_full;
  logic [10:0] frame;
  logic        move_go;

  assign c_s      = cs_q[1];
  assign d_s      = ds_q[1];
  assign half_end = (cnt == HALF_M1);
  assign rx_byte  = rx_sr[7:0];
  assign frame_ok = (^rx_sr[8:0]) & rx_sr[9];
  assign frame    = {1'b1, odd_par(fifo_rdata), fifo_rdata, 1'b0};

  assign move_go = (state == S_IDLE) & c_s & streaming & fifo_empty
                 & ~fifo_full & (pend_n == '0) & move_valid;
  assign move_ready = move_go;

  ps2_byte_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pend_n != '0),
    .wdata (pend[7:0]),
    .pop   (pop),
    .flush (ack_done),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    h_nx     = h;
    mclk_nx  = 1'b0;
    mdat_nx  = 1'b0;
    pop      = 1'b0;
    ack_done = 1'b0;
    rx_shift = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_nx = '0;
        h_nx   = '0;
        if (!c_s) state_nx = S_INHIBIT;
        else if (!fifo_empty) state_nx = S_GAP;
      end
      S_INHIBIT: begin
        if (!c_s) begin
          if (cnt < RTS) cnt_nx = cnt + 16'd1;
        end else begin
          cnt_nx   = '0;
          h_nx     = '0;
          state_nx = (cnt >= RTS && !d_s) ? S_RX : S_IDLE;
        end
      end
      S_RX: begin
        mclk_nx  = h[0];
        rx_shift = !h[0] && (h != '0) && (cnt == MID);
        cnt_nx   = half_end ? '0 : cnt + 16'd1;
        if (half_end) begin
          h_nx = (h == 5'd20) ? '0 : h + 5'd1;
          if (h == 5'd20) state_nx = S_ACK;
        end
      end
      S_ACK: begin
        mdat_nx = 1'b1;
        mclk_nx = (h == '0);
        cnt_nx  = half_end ? '0 : cnt + 16'd1;
        if (half_end) begin
          h_nx = h + 5'd1;
          if (h == 5'd1) begin
            state_nx = S_IDLE;
            ack_done = 1'b1;
          end
        end
      end
      S_GAP: begin
        cnt_nx = cnt + 16'd1;
        if (!c_s) begin
          state_nx = S_INHIBIT;
          cnt_nx   = '0;
        end else if (cnt == GAP_M1) begin
          state_nx = S_TX;
          cnt_nx   = '0;
          h_nx     = '0;
        end
      end
      S_TX: begin
        mclk_nx = h[0];
        mdat_nx = ~frame[h[4:1]];
        // Skip the first cycles of a high half: the released clock
        // needs time to come back through the synchronizer.
        if (!h[0] && cnt >= 16'd4 && !c_s) begin
          state_nx = S_INHIBIT;
          cnt_nx   = '0;
          h_nx     = '0;
          mclk_nx  = 1'b0;
          mdat_nx  = 1'b0;
        end else begin
          cnt_nx = half_end ? '0 : cnt + 16'd1;
          if (half_end) begin
            h_nx = h + 5'd1;
            if (h == 5'd21) begin
              state_nx = S_IDLE;
              h_nx     = '0;
              pop      = 1'b1;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q      <= 2'b11;
      ds_q      <= 2'b11;
      state     <= S_IDLE;
      cnt       <= '0;
      h         <= '0;
      mclk_oe   <= 1'b0;
      mdat_oe   <= 1'b0;
      rx_sr     <= '0;
      pend      <= '0;
      pend_n    <= '0;
      rate_mode <= 1'b0;
      hist1     <= '0;
      hist2     <= '0;
      streaming <= 1'b0;
      dev_id    <= ID_STD;
    end else begin
      cs_q    <= {cs_q[0], mclk_in};
      ds_q    <= {ds_q[0], mdat_in};
      state   <= state_nx;
      cnt     <= cnt_nx;
      h       <= h_nx;
      mclk_oe <= mclk_nx;
      mdat_oe <= mdat_nx;
      if (rx_shift) rx_sr <= {d_s, rx_sr[9:1]};
      if (pend_n != '0) begin
        pend   <= {8'h00, pend[31:8]};
        pend_n <= pend_n - 3'd1;
      end
      if (move_go) begin
        pend   <= {{4{dz[3]}}, dz, dy, dx,
                   2'b00, dy[7], dx[7], 1'b1, btn};
        pend_n <= (dev_id == ID_WHEEL) ? 3'd4 : 3'd3;
      end
      if (ack_done) begin
        pend   <= {24'h0, RSP_ACK};
        pend_n <= 3'd1;
        if (!frame_ok) begin
          pend <= {24'h0, RSP_ERR};
        end else if (rate_mode) begin
          // Only the two newest rates are needed to spot the magic run.
          rate_mode <= 1'b0;
          hist1     <= hist2;
          hist2     <= rx_byte;
          if (hist1 == RATE_M0 && hist2 == RATE_M1
              && rx_byte == RATE_M2) dev_id <= ID_WHEEL;
        end else begin
          unique case (1'b1)
            (rx_byte == CMD_RESET): begin
              pend      <= {8'h0, ID_STD, RSP_BAT, RSP_ACK};
              pend_n    <= 3'd3;
              streaming <= 1'b0;
              dev_id    <= ID_STD;
              hist1     <= '0;
              hist2     <= '0;
            end
            (rx_byte == CMD_RATE):    rate_mode <= 1'b1;
            (rx_byte == CMD_GETID): begin
              pend   <= {16'h0, dev_id, RSP_ACK};
              pend_n <= 3'd2;
            end
            (rx_byte == CMD_ENABLE):  streaming <= 1'b1;
            (rx_byte == CMD_DISABLE): streaming <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
